// File: rtl/jk_excite_driver_if.sv
// Command/feedback bundle between a JK excitation driver and its host plus the external JK bank.
interface jk_excite_driver_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;

  // Host / bank side: issues commands and returns the bank's Q.
  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output q_fb,
    input  cmd_ready,
    input  j_out,
    input  k_out,
    input  done,
    input  err,
    input  result
  );

  // Driver side.
  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  q_fb,
    output cmd_ready,
    output j_out,
    output k_out,
    output done,
    output err,
    output result
  );
endinterface

// File: rtl/jk_excite_driver.sv
// Drives J/K excitation into an external JK flip-flop bank to reach a commanded value,
// checks the bank's Q feedback one cycle later and re-drives up to MAX_RETRY times.
module jk_excite_driver #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_RETRY = 2
) (
  input logic               clk,
  input logic               rst_n,
  jk_excite_driver_if.slave bus
);

  localparam int unsigned RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [1:0] OpLoad   = 2'b00;
  localparam logic [1:0] OpInc    = 2'b01;
  localparam logic [1:0] OpDec    = 2'b10;
  localparam logic [1:0] OpToggle = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StCheck
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    target_q, target_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [WIDTH-1:0]    j_q, j_d;
  logic [WIDTH-1:0]    k_q, k_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [WIDTH-1:0]    cmd_target;
  logic                accept;
  logic                match;
  logic                can_retry;

  // Set bits that are 0 and must become 1.
  function automatic logic [WIDTH-1:0] jk_j(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
    return ~q & t;
  endfunction

  // Reset bits that are 1 and must become 0.
  function automatic logic [WIDTH-1:0] jk_k(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
    return q & ~t;
  endfunction

  // Target value for an incoming command, modulo 2^WIDTH (wrap is silent).
  always_comb begin
    cmd_target = bus.cmd_data;
    case (bus.cmd_op)
      OpLoad:   cmd_target = bus.cmd_data;
      OpInc:    cmd_target = bus.q_fb + WIDTH'(1);
      OpDec:    cmd_target = bus.q_fb - WIDTH'(1);
      OpToggle: cmd_target = bus.q_fb ^ bus.cmd_data;
      default:  cmd_target = bus.cmd_data;
    endcase
  end

  // ready_q gates acceptance so nothing is taken until one edge after reset release.
  assign accept    = (state_q == StIdle) && ready_q && bus.cmd_valid;
  assign match     = (bus.q_fb == target_q);
  assign can_retry = (32'(retry_q) < MAX_RETRY);

  // Next-state and registered-output logic; j/k default to zero outside the drive cycle.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    retry_d  = retry_q;
    j_d      = '0;
    k_d      = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ready_d  = ready_q;
    result_d = result_q;

    case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        if (accept) begin
          target_d = cmd_target;
          retry_d  = '0;
          ready_d  = 1'b0;
          state_d  = StDrive;
          if (bus.cmd_op == OpToggle) begin
            // First toggle drive uses J=K=mask so the bank flips the masked bits itself.
            j_d = bus.cmd_data;
            k_d = bus.cmd_data;
          end else begin
            j_d = jk_j(bus.q_fb, cmd_target);
            k_d = jk_k(bus.q_fb, cmd_target);
          end
        end
      end

      StDrive: begin
        ready_d = 1'b0;
        state_d = StCheck;
      end

      StCheck: begin
        if (match) begin
          result_d = bus.q_fb;
          done_d   = 1'b1;
          ready_d  = 1'b1;
          state_d  = StIdle;
        end else if (can_retry) begin
          // Retries always use set/reset excitation toward the fixed target, even for TOGGLE.
          retry_d = retry_q + RetryW'(1);
          j_d     = jk_j(bus.q_fb, target_q);
          k_d     = jk_k(bus.q_fb, target_q);
          ready_d = 1'b0;
          state_d = StDrive;
        end else begin
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = StIdle;
        end
      end

      default: begin
        ready_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; asynchronous reset clears everything including cmd_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      target_q <= '0;
      retry_q  <= '0;
      j_q      <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      retry_q  <= retry_d;
      j_q      <= j_d;
      k_q      <= k_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.j_out     = j_q;
  assign bus.k_out     = k_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Directed bench for jk_excite_driver with an ideal (optionally stuck) JK bank model
// and a completion scoreboard.
module tb_jk_excite_driver;

  logic clk;
  logic rst_n;

  jk_excite_driver_if #(.WIDTH(8)) bus ();

  jk_excite_driver #(
    .WIDTH     (8),
    .MAX_RETRY (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External JK bank: Q' = J&~Q | ~K&Q, loaded directly when bank_set, frozen when stuck.
  logic [7:0] q_bank;
  logic [7:0] bank_val;
  logic       bank_set;
  logic       bank_stuck;

  always @(posedge clk) begin
    if (bank_set) q_bank <= bank_val;
    else if (!bank_stuck) q_bank <= (bus.j_out & ~q_bank) | (~bus.k_out & q_bank);
  end

  assign bus.q_fb = q_bank;

  typedef struct packed {
    logic       ok;
    logic [7:0] res;
  } exp_t;

  exp_t sb_q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   done_cnt = 0;
  int   err_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Completion monitor: every done/err pops one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus.done === 1'b1 || bus.err === 1'b1)) begin
      if (bus.done) done_cnt++;
      if (bus.err) err_cnt++;
      chk("done_err_exclusive", {31'd0, bus.done & bus.err}, 32'd0);
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_completion: observed done=%0b err=%0b expected none",
               bus.done, bus.err);
      end
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_kind_done", {31'd0, bus.done}, {31'd0, e.ok});
        chk("sb_result", {24'd0, bus.result}, {24'd0, e.res});
      end
    end
  end

  task automatic set_q(input logic [7:0] v);
    bank_set = 1'b1;
    bank_val = v;
    @(negedge clk);
    bank_set = 1'b0;
  endtask

  // Issue one command from a negedge with cmd_ready high; ends at the negedge of the done/err cycle.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] data,
                         input logic [7:0] exp_j, input logic [7:0] exp_k,
                         input logic [7:0] exp_res);
    exp_t e;
    chk({tag, "_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    e.ok  = 1'b1;
    e.res = exp_res;
    sb_q.push_back(e);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk({tag, "_j"}, {24'd0, bus.j_out}, {24'd0, exp_j});
    chk({tag, "_k"}, {24'd0, bus.k_out}, {24'd0, exp_k});
    chk({tag, "_busy"}, {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    chk({tag, "_jk_idle"}, {16'd0, bus.j_out, bus.k_out}, 32'd0);
    chk({tag, "_nodone_early"}, {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_ready_in_done"}, {31'd0, bus.cmd_ready}, 32'd1);
    chk({tag, "_result"}, {24'd0, bus.result}, {24'd0, exp_res});
  endtask

  initial begin
    int drv;
    int err_at;
    int dn;
    exp_t e;

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 8'h00;
    bank_set      = 1'b0;
    bank_stuck    = 1'b0;
    bank_val      = 8'h00;

    // Reset state
    #1;
    chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("rst_jk", {16'd0, bus.j_out, bus.k_out}, 32'd0);
    chk("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
    chk("rst_result", {24'd0, bus.result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_ready_pre_edge", {31'd0, bus.cmd_ready}, 32'd0);
    set_q(8'h00);
    chk("rel_ready_post_edge", {31'd0, bus.cmd_ready}, 32'd1);

    // Scenario 1: LOAD from zero
    run_cmd("s1_load", 2'b00, 8'hA5, 8'hA5, 8'h00, 8'hA5);

    // Scenario 2: INC wrap and DEC wrap
    set_q(8'hFF);
    run_cmd("s2_inc", 2'b01, 8'h00, 8'h00, 8'hFF, 8'h00);
    set_q(8'h00);
    run_cmd("s2_dec", 2'b10, 8'h00, 8'hFF, 8'h00, 8'hFF);
    set_q(8'h7F);
    run_cmd("inc_carry", 2'b01, 8'hEE, 8'h80, 8'h7F, 8'h80);

    // Scenario 3: TOGGLE
    set_q(8'h3C);
    run_cmd("s3_toggle", 2'b11, 8'h0F, 8'h0F, 8'h0F, 8'h33);

    // Scenario 4: bank stuck at 0x12, LOAD 0x34 exhausts retries
    set_q(8'h12);
    bank_stuck = 1'b1;
    e.ok  = 1'b0;
    e.res = 8'h33;
    sb_q.push_back(e);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 8'h34;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    drv    = 0;
    err_at = 0;
    dn     = 0;
    for (int i = 1; i <= 9; i++) begin
      if (bus.j_out != 8'h00 || bus.k_out != 8'h00) begin
        drv++;
        chk("s4_j", {24'd0, bus.j_out}, 32'h24);
        chk("s4_k", {24'd0, bus.k_out}, 32'h02);
      end
      if (bus.err) err_at = i;
      if (bus.done) dn++;
      @(negedge clk);
    end
    chk("s4_drive_cycles", drv, 32'd3);
    chk("s4_err_cycle", err_at, 32'd7);
    chk("s4_no_done", dn, 32'd0);
    chk("s4_result_kept", {24'd0, bus.result}, 32'h33);
    bank_stuck = 1'b0;

    // Scenario 5: reset during DRIVE
    set_q(8'h00);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 8'h55;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("s5_j_drive", {24'd0, bus.j_out}, 32'h55);
    #1 rst_n = 1'b0;
    #1;
    chk("s5_jk_async", {16'd0, bus.j_out, bus.k_out}, 32'd0);
    chk("s5_ready_async", {31'd0, bus.cmd_ready}, 32'd0);
    chk("s5_result_async", {24'd0, bus.result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("s5_ready_pre_edge", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    chk("s5_ready_post_edge", {31'd0, bus.cmd_ready}, 32'd1);
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done || bus.err) dn++;
      @(negedge clk);
    end
    chk("s5_no_completion", dn, 32'd0);

    // Scenario 6: cmd_valid held across two LOADs (bank Q is 0x00)
    e.ok  = 1'b1;
    e.res = 8'h5A;
    sb_q.push_back(e);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_data = 8'hC3;
    e.res = 8'hC3;
    sb_q.push_back(e);
    chk("s6_j1", {24'd0, bus.j_out}, 32'h5A);
    chk("s6_k1", {24'd0, bus.k_out}, 32'h00);
    chk("s6_busy1", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    chk("s6_busy2", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    chk("s6_done1", {31'd0, bus.done}, 32'd1);
    chk("s6_ready_done1", {31'd0, bus.cmd_ready}, 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("s6_j2", {24'd0, bus.j_out}, 32'h81);
    chk("s6_k2", {24'd0, bus.k_out}, 32'h18);
    @(negedge clk);
    @(negedge clk);
    chk("s6_done2", {31'd0, bus.done}, 32'd1);
    chk("s6_result2", {24'd0, bus.result}, 32'hC3);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    chk("total_done", done_cnt, 32'd7);
    chk("total_err", err_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
